// File: rtl/counter_pkg.sv
// Shared constants for the parametrised counter: default widths and mode encodings.
package counter_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 4;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_MOD     = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable clock-enable divider: tick fires once every prescale+1 enabled cycles.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt;

    // Compare with >= so that lowering prescale below pre_cnt ticks on the next enabled edge.
    assign tick = en && ena && (pre_cnt >= prescale);

    // Divider state: frozen by ena, restarted by load, wrapped on tick, held while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (ena) begin
            if (clr || tick) begin
                pre_cnt <= '0;
            end else if (en) begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_counter.sv
// WIDTH-bit up/down counter with load, prescaler, four terminal-count modes and tc/done flags.
module param_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  en,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  done
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic             tick;
    logic [WIDTH-1:0] cnt_nxt;
    logic             term;

    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .en       (en),
        .clr      (load),
        .prescale (prescale),
        .tick     (tick)
    );

    // Next count and terminal-event flag for a tick, per mode and direction.
    always_comb begin
        cnt_nxt = count;
        term    = 1'b0;
        case (mode)
            MODE_WRAP: begin
                cnt_nxt = dir ? count + CNT_ONE : count - CNT_ONE;
                term    = dir ? (count == CNT_MAX) : (count == '0);
            end
            MODE_SAT: begin
                if (dir) begin
                    if (count != CNT_MAX) cnt_nxt = count + CNT_ONE;
                    term = (count == CNT_MAX - CNT_ONE);
                end else begin
                    if (count != '0) cnt_nxt = count - CNT_ONE;
                    term = (count == CNT_ONE);
                end
            end
            default: begin
                // Modulo and one-shot share the stepping; they differ in what counts as terminal.
                if (dir) begin
                    cnt_nxt = (count >= limit) ? '0 : count + CNT_ONE;
                end else begin
                    cnt_nxt = (count == '0) ? limit : count - CNT_ONE;
                end
                if (mode == MODE_MOD) begin
                    term = dir ? (count >= limit) : (count == '0);
                end else begin
                    term = dir ? ((count + CNT_ONE) == limit) : (count == CNT_ONE);
                end
            end
        endcase
    end

    // Registered count/tc/done: ena freezes everything, load beats tick, done blocks one-shot ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (ena) begin
            tc <= 1'b0;
            if (mode != MODE_ONESHOT) done <= 1'b0;
            if (load) begin
                count <= load_val;
                done  <= 1'b0;
            end else if (tick && !(mode == MODE_ONESHOT && done)) begin
                count <= cnt_nxt;
                tc    <= term;
                if (mode == MODE_ONESHOT && term) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: expectations queued per cycle, compared against captured outputs.
module tb_param_counter;
    import counter_pkg::*;

    typedef struct packed {
        logic [7:0] c;
        logic       t;
        logic       d;
    } smp_t;

    logic       clk = 1'b0;
    logic       rst_n, ena, en, dir, load;
    logic [1:0] mode;
    logic [7:0] load_val, limit, count;
    logic [3:0] prescale;
    logic       tc, done;

    smp_t sb[$];
    smp_t obs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    param_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_val(load_val), .limit(limit), .prescale(prescale),
        .count(count), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    // One clock: drive load/en at negedge, queue expectation, capture outputs at next negedge.
    task automatic cyc(input logic ld, input logic [7:0] lv, input logic e,
                       input logic [7:0] ec, input logic et, input logic ed);
        load = ld; load_val = lv; en = e;
        sb.push_back('{ec, et, ed});
        @(posedge clk);
        @(negedge clk);
        obs.push_back('{count, tc, done});
    endtask

    task automatic test_reset();
        smp_t ex, ob;
        rst_n = 1'b0; ena = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0;
        mode = MODE_WRAP; load_val = '0; limit = '0; prescale = '0;
        repeat (3) @(negedge clk);
        sb.push_back('{8'd0, 1'b0, 1'b0});
        obs.push_back('{count, tc, done});
        while (sb.size() > 0) begin
            ex = sb.pop_front(); ob = obs.pop_front(); n_tests++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL reset: got c=%0d tc=%b done=%b want c=%0d tc=%b done=%b", ob.c, ob.t, ob.d, ex.c, ex.t, ex.d);
            end
        end
    endtask

    task automatic test_wrap();
        smp_t ex, ob;
        int   i;
        rst_n = 1'b1; ena = 1'b1; dir = 1'b1; mode = MODE_WRAP; prescale = 4'd0;
        for (int k = 1; k <= 256; k++) cyc(1'b0, 8'd0, 1'b1, 8'(k), (k == 256), 1'b0);
        dir = 1'b0;
        cyc(1'b0, 8'd0, 1'b1, 8'd255, 1'b1, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            ex = sb.pop_front(); ob = obs.pop_front(); n_tests++; i++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got c=%0d tc=%b done=%b want c=%0d tc=%b done=%b", i, ob.c, ob.t, ob.d, ex.c, ex.t, ex.d);
            end
        end
    endtask

    task automatic test_prescale_down();
        smp_t ex, ob;
        int   i;
        mode = MODE_WRAP; dir = 1'b0; prescale = 4'd3;
        cyc(1'b1, 8'd5, 1'b1, 8'd5, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) cyc(1'b0, 8'd0, 1'b1, (k < 4) ? 8'd5 : (k < 8) ? 8'd4 : 8'd3, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd3, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd3, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 8'd0, 1'b0, 8'd3, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd3, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd2, 1'b0, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            ex = sb.pop_front(); ob = obs.pop_front(); n_tests++; i++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL prescale_down[%0d]: got c=%0d tc=%b done=%b want c=%0d tc=%b done=%b", i, ob.c, ob.t, ob.d, ex.c, ex.t, ex.d);
            end
        end
    endtask

    task automatic test_saturate();
        smp_t ex, ob;
        int   i;
        mode = MODE_SAT; dir = 1'b1; prescale = 4'd0;
        cyc(1'b1, 8'd253, 1'b1, 8'd253, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd254, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd255, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, 8'd0, 1'b1, 8'd255, 1'b0, 1'b0);
        dir = 1'b0;
        cyc(1'b0, 8'd0, 1'b1, 8'd254, 1'b0, 1'b0);
        cyc(1'b1, 8'd1, 1'b1, 8'd1, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            ex = sb.pop_front(); ob = obs.pop_front(); n_tests++; i++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL saturate[%0d]: got c=%0d tc=%b done=%b want c=%0d tc=%b done=%b", i, ob.c, ob.t, ob.d, ex.c, ex.t, ex.d);
            end
        end
    endtask

    task automatic test_modulo();
        smp_t ex, ob;
        int   i;
        mode = MODE_MOD; dir = 1'b1; prescale = 4'd0; limit = 8'd9;
        cyc(1'b1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) cyc(1'b0, 8'd0, 1'b1, 8'(k), 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0);
        cyc(1'b1, 8'd12, 1'b1, 8'd12, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0);
        dir = 1'b0;
        cyc(1'b0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b0);
        cyc(1'b1, 8'd12, 1'b1, 8'd12, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd11, 1'b0, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            ex = sb.pop_front(); ob = obs.pop_front(); n_tests++; i++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL modulo[%0d]: got c=%0d tc=%b done=%b want c=%0d tc=%b done=%b", i, ob.c, ob.t, ob.d, ex.c, ex.t, ex.d);
            end
        end
    endtask

    task automatic test_oneshot();
        smp_t ex, ob;
        int   i;
        mode = MODE_ONESHOT; dir = 1'b1; prescale = 4'd0; limit = 8'd9;
        cyc(1'b1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) cyc(1'b0, 8'd0, 1'b1, 8'(k), 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 8'd0, 1'b1, 8'd9, 1'b0, 1'b1);
        cyc(1'b1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) cyc(1'b0, 8'd0, 1'b1, 8'(k), 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b1);
        mode = MODE_MOD;
        cyc(1'b0, 8'd0, 1'b0, 8'd9, 1'b0, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            ex = sb.pop_front(); ob = obs.pop_front(); n_tests++; i++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL oneshot[%0d]: got c=%0d tc=%b done=%b want c=%0d tc=%b done=%b", i, ob.c, ob.t, ob.d, ex.c, ex.t, ex.d);
            end
        end
    endtask

    task automatic test_load_vs_tick();
        smp_t ex, ob;
        int   i;
        mode = MODE_WRAP; dir = 1'b1; prescale = 4'd0;
        cyc(1'b1, 8'd255, 1'b1, 8'd255, 1'b0, 1'b0);
        cyc(1'b1, 8'h40, 1'b1, 8'h40, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'h41, 1'b0, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            ex = sb.pop_front(); ob = obs.pop_front(); n_tests++; i++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL load_vs_tick[%0d]: got c=%0d tc=%b done=%b want c=%0d tc=%b done=%b", i, ob.c, ob.t, ob.d, ex.c, ex.t, ex.d);
            end
        end
    endtask

    task automatic test_reset_mid();
        smp_t ex, ob;
        int   i;
        mode = MODE_ONESHOT; dir = 1'b1; prescale = 4'd0; limit = 8'h17;
        cyc(1'b1, 8'h16, 1'b1, 8'h16, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'h17, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        sb.push_back('{8'd0, 1'b0, 1'b0});
        obs.push_back('{count, tc, done});
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            ex = sb.pop_front(); ob = obs.pop_front(); n_tests++; i++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got c=%0d tc=%b done=%b want c=%0d tc=%b done=%b", i, ob.c, ob.t, ob.d, ex.c, ex.t, ex.d);
            end
        end
    endtask

    task automatic test_ena_freeze();
        smp_t ex, ob;
        int   i;
        mode = MODE_WRAP; dir = 1'b1; prescale = 4'd0;
        cyc(1'b1, 8'd255, 1'b1, 8'd255, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0);
        ena = 1'b0;
        repeat (10) cyc(1'b1, 8'hAA, 1'b1, 8'd0, 1'b1, 1'b0);
        ena = 1'b1;
        cyc(1'b0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            ex = sb.pop_front(); ob = obs.pop_front(); n_tests++; i++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL ena_freeze[%0d]: got c=%0d tc=%b done=%b want c=%0d tc=%b done=%b", i, ob.c, ob.t, ob.d, ex.c, ex.t, ex.d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_prescale_down();
        test_saturate();
        test_modulo();
        test_oneshot();
        test_load_vs_tick();
        test_reset_mid();
        test_ena_freeze();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
